// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 command transmitter. Holds the clock low to inhibit the
// device, issues the request-to-send (data low, clock released), then shifts
// out eight data bits LSB first, odd parity and the stop bit on the falling
// edges the device generates. The device ACK bit is checked at the end.
// Both lines are open-drain: the block only ever pulls them low or floats them.
//
// Ports:
//   clk        system clock (100 MHz nominal)
//   rst        asynchronous, active-high reset; releases both lines at once
//   tx_data    command byte, captured when a request is accepted
//   tx_valid   send request, accepted only while tx_ready is high
//   tx_ready   high only while idle
//   tx_done    one-cycle pulse: byte sent and device ACK seen
//   tx_err     one-cycle pulse: NACK or watchdog timeout
//   err_code   00 none, 01 NACK, 10 timeout; held until the next accept
//   bus_owned  high for the whole transfer so the receive path ignores the bus
//   PS2_CLK    open-drain clock line (0 or z)
//   PS2_DATA   open-drain data line (0 or z)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       bus_owned,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    // Terminal values of the shared phase/watchdog counter.
    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] REQ_LAST = 32'(REQ_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    // Odd parity bit for a data byte: set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t      state_r;
    logic        clk_low_r;
    logic        data_low_r;
    logic [9:0]  shreg_r;
    logic [3:0]  bitcnt_r;
    logic [31:0] cnt_r;
    logic [1:0]  err_code_r;
    logic        tx_done_r;
    logic        tx_err_r;
    logic        tx_ready_r;
    logic        bus_owned_r;
    logic [1:0]  clk_sync_r;
    logic [1:0]  data_sync_r;
    logic        clk_prev_r;
    logic        fe_s;

    assign PS2_CLK   = clk_low_r  ? 1'b0 : 1'bz;
    assign PS2_DATA  = data_low_r ? 1'b0 : 1'bz;

    assign tx_ready  = tx_ready_r;
    assign tx_done   = tx_done_r;
    assign tx_err    = tx_err_r;
    assign err_code  = err_code_r;
    assign bus_owned = bus_owned_r;

    // Falling edge of the synchronised device clock.
    assign fe_s = clk_prev_r & ~clk_sync_r[1];

    // Two-flop synchronisers for both lines plus one history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], PS2_CLK};
            data_sync_r <= {data_sync_r[0], PS2_DATA};
            clk_prev_r  <= clk_sync_r[1];
        end
    end

    // Transfer sequencer: line drive, bit shifting, ACK check, watchdog and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            clk_low_r   <= 1'b0;
            data_low_r  <= 1'b0;
            shreg_r     <= 10'd0;
            bitcnt_r    <= 4'd0;
            cnt_r       <= 32'd0;
            err_code_r  <= 2'b00;
            tx_done_r   <= 1'b0;
            tx_err_r    <= 1'b0;
            tx_ready_r  <= 1'b1;
            bus_owned_r <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            tx_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shreg_r     <= {1'b1, odd_parity(tx_data), tx_data};
                        err_code_r  <= 2'b00;
                        clk_low_r   <= 1'b1;
                        data_low_r  <= 1'b0;
                        cnt_r       <= 32'd0;
                        tx_ready_r  <= 1'b0;
                        bus_owned_r <= 1'b1;
                        state_r     <= ST_INHIBIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INHIBIT: begin
                    // Device edges here are our own clock pull-down and are ignored.
                    if (cnt_r == INH_LAST) begin
                        data_low_r <= 1'b1;
                        cnt_r      <= 32'd0;
                        state_r    <= ST_REQ;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_REQ: begin
                    // Start bit stays on DATA after the clock is released.
                    if (cnt_r == REQ_LAST) begin
                        clk_low_r <= 1'b0;
                        bitcnt_r  <= 4'd0;
                        cnt_r     <= 32'd0;
                        state_r   <= ST_SEND;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_SEND: begin
                    if (fe_s) begin
                        data_low_r <= ~shreg_r[bitcnt_r];
                        bitcnt_r   <= bitcnt_r + 4'd1;
                        cnt_r      <= 32'd0;
                        if (bitcnt_r == 4'd9) begin
                            state_r <= ST_ACK;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else if (cnt_r == TMO_LAST) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        err_code_r <= 2'b10;
                        tx_err_r   <= 1'b1;
                        state_r    <= ST_FAIL;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_ACK: begin
                    if (fe_s) begin
                        cnt_r <= 32'd0;
                        if (data_sync_r[1] == 1'b0) begin
                            state_r <= ST_WAIT_IDLE;
                        end else begin
                            err_code_r <= 2'b01;
                            tx_err_r   <= 1'b1;
                            state_r    <= ST_FAIL;
                        end
                    end else if (cnt_r == TMO_LAST) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        err_code_r <= 2'b10;
                        tx_err_r   <= 1'b1;
                        state_r    <= ST_FAIL;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Device must release both lines before the transfer counts as done.
                    if (clk_sync_r[1] && data_sync_r[1]) begin
                        tx_done_r   <= 1'b1;
                        tx_ready_r  <= 1'b1;
                        bus_owned_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (cnt_r == TMO_LAST) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        err_code_r <= 2'b10;
                        tx_err_r   <= 1'b1;
                        state_r    <= ST_FAIL;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_FAIL: begin
                    // tx_err was raised on entry, so it lasts exactly this one cycle.
                    tx_ready_r  <= 1'b1;
                    bus_owned_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    clk_low_r   <= 1'b0;
                    data_low_r  <= 1'b0;
                    tx_ready_r  <= 1'b1;
                    bus_owned_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
